// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: turns framed UART commands into single-word bus transactions.
//   Write frame: 0x57 addr[4] data[4] -> bus write -> reply 0x4B
//   Read frame:  0x52 addr[4]         -> bus read  -> reply rdata[4], LSB first
//   Other opcode                      -> reply 0x3F, no bus access
// Optional feature macro UART_BRIDGE_ACK_TIMEOUT_EN: abort a bus access after ACK_TIMEOUT
// cycles without ack and reply 0x45.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   rx_data_i, rx_ready_i     received byte and its one-cycle strobe
//   tx_data_o, tx_req_o       byte to transmit and its one-cycle strobe
//   tx_busy_i                 transmitter busy
//   bus_req_o, bus_we_o       one-cycle request strobe, write enable
//   bus_addr_o, bus_wdata_o   word address (bits [1:0] zero), write data
//   bus_rdata_i, bus_ack_i    read data, transaction complete
//   overrun_o                 sticky: byte arrived while busy with a transaction/reply
module uart_bus_bridge #(
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_req_o,
    input  logic        tx_busy_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        overrun_o
);

    localparam logic [7:0] OpWrite   = 8'h57;
    localparam logic [7:0] OpRead    = 8'h52;
    localparam logic [7:0] RespWrOk  = 8'h4B;
    localparam logic [7:0] RespBadOp = 8'h3F;

    typedef enum logic [2:0] {
        StIdle, StAddr, StData, StBusReq, StBusWait, StTxSend, StTxWait
    } state_e;

    state_e      state_q;
    logic [1:0]  cnt_q;     // byte counter while collecting; reply bytes left while sending
    logic        skip_q;    // first TX_WAIT cycle, before tx_busy_i has had a chance to rise
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] reply_q;   // reply bytes, next one to send in [7:0]
    logic [7:0]  tx_data_q;
    logic        tx_req_q;
    logic        bus_req_q;
    logic        overrun_q;
    logic [31:0] ack_reply;

    assign ack_reply   = we_q ? {24'h0, RespWrOk} : bus_rdata_i;
    assign tx_data_o   = tx_data_q;
    assign tx_req_o    = tx_req_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q & ~32'h3;
    assign bus_wdata_o = wdata_q;
    assign overrun_o   = overrun_q;

`ifdef UART_BRIDGE_ACK_TIMEOUT_EN
    localparam int unsigned TimeoutW = $clog2(ACK_TIMEOUT + 1);
    logic [TimeoutW-1:0] tmo_q;
`else
    logic [31:0] unused_ack_timeout;
    assign unused_ack_timeout = ACK_TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= 2'd0;
            skip_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            reply_q   <= 32'h0;
            tx_data_q <= 8'h0;
            tx_req_q  <= 1'b0;
            bus_req_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_BRIDGE_ACK_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            bus_req_q <= 1'b0;
            tx_req_q  <= 1'b0;
            if (rx_ready_i && (state_q inside {StBusReq, StBusWait, StTxSend, StTxWait})) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (rx_ready_i) begin
                        cnt_q <= 2'd0;
                        if (rx_data_i == OpWrite || rx_data_i == OpRead) begin
                            we_q    <= (rx_data_i == OpWrite);
                            state_q <= StAddr;
                        end else begin
                            reply_q <= {24'h0, RespBadOp};
                            state_q <= StTxSend;
                        end
                    end
                end
                StAddr: begin
                    if (rx_ready_i) begin
                        addr_q <= {rx_data_i, addr_q[31:8]};
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (we_q) begin
                                state_q <= StData;
                            end else begin
                                // Strobe raised here so it appears the cycle after the last byte.
                                bus_req_q <= 1'b1;
                                state_q   <= StBusReq;
                            end
                        end
                    end
                end
                StData: begin
                    if (rx_ready_i) begin
                        wdata_q <= {rx_data_i, wdata_q[31:8]};
                        cnt_q   <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            bus_req_q <= 1'b1;
                            state_q   <= StBusReq;
                        end
                    end
                end
                StBusReq: begin
`ifdef UART_BRIDGE_ACK_TIMEOUT_EN
                    tmo_q <= '0;
`endif
                    state_q <= StBusWait;
                end
                StBusWait: begin
                    if (bus_ack_i) begin
                        cnt_q <= we_q ? 2'd0 : 2'd3;
                        if (!tx_busy_i) begin
                            // Fast path: first reply byte goes out the cycle after ack.
                            tx_req_q  <= 1'b1;
                            tx_data_q <= ack_reply[7:0];
                            reply_q   <= {8'h0, ack_reply[31:8]};
                            skip_q    <= 1'b1;
                            state_q   <= StTxWait;
                        end else begin
                            reply_q <= ack_reply;
                            state_q <= StTxSend;
                        end
                    end
`ifdef UART_BRIDGE_ACK_TIMEOUT_EN
                    else if (tmo_q == TimeoutW'(ACK_TIMEOUT - 1)) begin
                        reply_q <= 32'h0000_0045;
                        cnt_q   <= 2'd0;
                        state_q <= StTxSend;
                    end else begin
                        tmo_q <= tmo_q + TimeoutW'(1);
                    end
`endif
                end
                StTxSend: begin
                    if (!tx_busy_i) begin
                        tx_req_q  <= 1'b1;
                        tx_data_q <= reply_q[7:0];
                        reply_q   <= {8'h0, reply_q[31:8]};
                        skip_q    <= 1'b1;
                        state_q   <= StTxWait;
                    end
                end
                StTxWait: begin
                    if (skip_q) begin
                        skip_q <= 1'b0;
                    end else if (!tx_busy_i) begin
                        if (cnt_q != 2'd0) begin
                            cnt_q   <= cnt_q - 2'd1;
                            state_q <= StTxSend;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge with a simple transmitter busy model.
module tb_uart_bus_bridge;
`ifdef UART_BRIDGE_ACK_TIMEOUT_EN
    localparam int unsigned Tmo = 16;
`else
    localparam int unsigned Tmo = 1023;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rx_data_i;
    logic        rx_ready_i;
    logic [7:0]  tx_data_o;
    logic        tx_req_o;
    logic        tx_busy_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        overrun_o;

    uart_bus_bridge #(.ACK_TIMEOUT(Tmo)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_data_i  (rx_data_i),
        .rx_ready_i (rx_ready_i),
        .tx_data_o  (tx_data_o),
        .tx_req_o   (tx_req_o),
        .tx_busy_i  (tx_busy_i),
        .bus_req_o  (bus_req_o),
        .bus_we_o   (bus_we_o),
        .bus_addr_o (bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i),
        .bus_ack_i  (bus_ack_i),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int req_cnt = 0;
    int req_cyc = 0;
    int tx_cyc = 0;
    int last_tx = -100;
    int gap_bad = 0;
    logic [7:0] txq[$];

    // Transmitter: busy rises the cycle after a request and stays up four cycles.
    assign tx_busy_i = (busy_cnt != 0);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_req_o) busy_cnt <= 4;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (bus_req_o) begin
            req_cnt = req_cnt + 1;
            req_cyc = cyc;
        end
        if (tx_req_o) begin
            if (cyc - last_tx < 2) gap_bad = gap_bad + 1;
            last_tx = cyc;
            tx_cyc  = cyc;
            txq.push_back(tx_data_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        send_byte(op);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (op == 8'h57) begin
            for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        end
    endtask

    // Request must appear one or two cycles after the last frame byte.
    task automatic wait_req(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (bus_req_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, {31'h0, seen}, 32'h1);
    endtask

    task automatic ack(input logic [31:0] d);
        @(posedge clk);
        #1;
        bus_ack_i   = 1'b1;
        bus_rdata_i = d;
        tick();
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h5555_AAAA;
    endtask

    task automatic wait_tx(input int n, input string tag);
        for (int k = 0; k < 200; k++) begin
            if (txq.size() >= n) break;
            tick();
        end
        repeat (8) tick();
        chk(tag, txq.size(), n);
    endtask

    int r0;

    initial begin
        rstn        = 1'b0;
        rx_data_i   = 8'h0;
        rx_ready_i  = 1'b0;
        bus_rdata_i = 32'h0;
        bus_ack_i   = 1'b0;
        #12;
        chk("rst_tx", {23'h0, tx_req_o, tx_data_o}, 32'h0);
        chk("rst_bus_ctl", {30'h0, bus_req_o, bus_we_o}, 32'h0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        chk("rst_overrun", {31'h0, overrun_o}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Write frame, ack one cycle after the request.
        txq.delete();
        r0 = req_cnt;
        send_frame(8'h57, 32'h8000_0010, 32'hDEAD_BEEF);
        wait_req("wr_req");
        chk("wr_we", {31'h0, bus_we_o}, 32'h1);
        chk("wr_addr", bus_addr_o, 32'h8000_0010);
        chk("wr_wdata", bus_wdata_o, 32'hDEAD_BEEF);
        ack(32'h0);
        @(negedge clk);
        chk("wr_tx_lat", {23'h0, tx_req_o, tx_data_o}, {23'h0, 1'b1, 8'h4B});
        wait_tx(1, "wr_tx_cnt");
        chk("wr_reply", txq[0], 32'h4B);
        chk("wr_one_req", req_cnt - r0, 32'd1);

        // Read frame, four reply bytes LSB first.
        txq.delete();
        send_frame(8'h52, 32'h8000_0004, 32'h0);
        wait_req("rd_req");
        chk("rd_we", {31'h0, bus_we_o}, 32'h0);
        chk("rd_addr", bus_addr_o, 32'h8000_0004);
        ack(32'h1234_5678);
        wait_tx(4, "rd_tx_cnt");
        chk("rd_b0", txq[0], 32'h78);
        chk("rd_b1", txq[1], 32'h56);
        chk("rd_b2", txq[2], 32'h34);
        chk("rd_b3", txq[3], 32'h12);

        // Unaligned address: low two bits dropped.
        txq.delete();
        send_frame(8'h52, 32'h0000_0107, 32'h0);
        wait_req("ua_req");
        chk("ua_addr", bus_addr_o, 32'h0000_0104);
        ack(32'hCAFE_F00D);
        wait_tx(4, "ua_tx_cnt");
        chk("ua_reply", {txq[3], txq[2], txq[1], txq[0]}, 32'hCAFE_F00D);

        // Unknown opcode: no bus access, reply 0x3F.
        txq.delete();
        r0 = req_cnt;
        send_byte(8'hA5);
        wait_tx(1, "bad_tx_cnt");
        chk("bad_reply", txq[0], 32'h3F);
        chk("bad_no_req", req_cnt - r0, 32'd0);

        // Byte during BUS_WAIT sets sticky overrun; transaction unaffected.
        chk("ovr_clear", {31'h0, overrun_o}, 32'h0);
        txq.delete();
        send_frame(8'h52, 32'h0000_0008, 32'h0);
        wait_req("ovr_req");
        tick();
        send_byte(8'h99);
        @(negedge clk);
        chk("ovr_set", {31'h0, overrun_o}, 32'h1);
        ack(32'h0BAD_F00D);
        wait_tx(4, "ovr_tx_cnt");
        chk("ovr_reply", {txq[3], txq[2], txq[1], txq[0]}, 32'h0BAD_F00D);
        chk("ovr_sticky", {31'h0, overrun_o}, 32'h1);

`ifdef UART_BRIDGE_ACK_TIMEOUT_EN
        // No ack: single 0x45 after the timeout; a late ack is ignored.
        txq.delete();
        r0 = req_cnt;
        send_frame(8'h52, 32'h0000_0040, 32'h0);
        wait_req("tmo_req");
        wait_tx(1, "tmo_tx_cnt");
        chk("tmo_reply", txq[0], 32'h45);
        chk("tmo_delay", {31'h0, (tx_cyc - req_cyc >= 17) && (tx_cyc - req_cyc <= 19)}, 32'h1);
        ack(32'hFFFF_FFFF);
        repeat (10) tick();
        chk("tmo_late_ack", txq.size(), 32'd1);
        chk("tmo_one_req", req_cnt - r0, 32'd1);
`endif

        // Reset while waiting between read reply bytes.
        txq.delete();
        send_frame(8'h52, 32'h0000_000C, 32'h0);
        wait_req("rr_req");
        ack(32'h1122_3344);
        tick();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("rr_tx0", {23'h0, tx_req_o, tx_data_o}, 32'h0);
        chk("rr_bus0", {30'h0, bus_req_o, bus_we_o}, 32'h0);
        chk("rr_addr0", bus_addr_o, 32'h0);
        chk("rr_ovr0", {31'h0, overrun_o}, 32'h0);
        repeat (3) tick();
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) tick();
        chk("rr_no_more_tx", txq.size(), 32'd1);
        txq.delete();
        send_frame(8'h57, 32'h0000_0020, 32'h0000_0001);
        wait_req("rr_wr_req");
        chk("rr_wr_addr", bus_addr_o, 32'h0000_0020);
        chk("rr_wr_wdata", bus_wdata_o, 32'h0000_0001);
        ack(32'h0);
        wait_tx(1, "rr_wr_tx_cnt");
        chk("rr_wr_reply", txq[0], 32'h4B);

        chk("tx_spacing", gap_bad, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
